// File: rtl/jk_pkg.sv
// Shared types and the per-bit next-state rule for the JK register bank.
package jk_pkg;

  typedef enum logic [1:0] {MODE_JK, MODE_D, MODE_T, MODE_SR} mode_t;

  typedef enum logic [1:0] {ST_RESET, ST_INIT, ST_RUN} ctl_state_t;

  function automatic int ch_w(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

  // SR is reset-dominant: k wins when both are high.
  function automatic logic jk_next(input mode_t mode, input logic q, input logic j, input logic k);
    logic r;
    r = q;
    case (mode)
      MODE_JK: begin
        case ({j, k})
          2'b00:   r = q;
          2'b01:   r = 1'b0;
          2'b10:   r = 1'b1;
          default: r = ~q;
        endcase
      end
      MODE_D:  r = j;
      MODE_T:  r = j ? ~q : q;
      MODE_SR: r = k ? 1'b0 : (j ? 1'b1 : q);
      default: r = q;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/jk_reg_bank_if.sv
// Mode-configuration handshake between a host and the register bank.
interface jk_reg_bank_if #(
  parameter int CH_W = 2
) ();
  import jk_pkg::*;

  logic            cfg_valid;
  logic [CH_W-1:0] cfg_ch;
  mode_t           cfg_mode;
  logic            cfg_ready;

  modport master (output cfg_valid, output cfg_ch, output cfg_mode, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_ch, input cfg_mode, output cfg_ready);
endinterface

// File: rtl/jk_channel.sv
// One WIDTH-bit register channel: mode register, data flops, change pulse and
// saturating change counter.
module jk_channel
  import jk_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter int               CNT_W   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic             mode_we,
  input  mode_t            mode_wdata,
  input  logic             cnt_clr,
  output logic [WIDTH-1:0] q,
  output logic             chg,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  mode_t            mode;
  logic [WIDTH-1:0] q_nxt;
  logic             changed;

  always_comb begin
    q_nxt = q;
    if (en) begin
      for (int b = 0; b < WIDTH; b++) begin
        q_nxt[b] = jk_next(mode, q[b], j[b], k[b]);
      end
    end
  end

  assign changed = (q_nxt != q);

  // A mode write lands on the same edge as the data update, so that update
  // still sees the old mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      q    <= RST_VAL;
      mode <= MODE_JK;
      chg  <= 1'b0;
      cnt  <= '0;
    end else begin
      q   <= q_nxt;
      chg <= changed;
      if (mode_we) begin
        mode <= mode_wdata;
      end
      if (cnt_clr) begin
        cnt <= '0;
      end else if (changed && (cnt != CNT_MAX)) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/jk_reg_bank.sv
// Bank of NCH JK-style registers with a small control FSM gating mode writes.
// state    | meaning
// ST_RESET | reset seen, configuration closed
// ST_INIT  | first cycle after release, data live, configuration closed
// ST_RUN   | configuration writes accepted
module jk_reg_bank
  import jk_pkg::*;
#(
  parameter int               NCH     = 4,
  parameter int               WIDTH   = 8,
  parameter int               CNT_W   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH*WIDTH-1:0] j,
  input  logic [NCH*WIDTH-1:0] k,
  input  logic [NCH-1:0]       en,
  jk_reg_bank_if.slave         cfg,
  output logic [NCH*WIDTH-1:0] q,
  output logic [NCH-1:0]       chg,
  input  logic [NCH-1:0]       cnt_clr,
  output logic [NCH*CNT_W-1:0] cnt
);

  localparam int CH_W = ch_w(NCH);

  ctl_state_t state;
  logic       ready_q;
  logic       cfg_fire;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_RESET;
      ready_q <= 1'b0;
    end else begin
      case (state)
        ST_RESET: begin
          state   <= ST_INIT;
          ready_q <= 1'b0;
        end
        ST_INIT: begin
          state   <= ST_RUN;
          ready_q <= 1'b1;
        end
        default: begin
          state   <= ST_RUN;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign cfg.cfg_ready = ready_q;
  assign cfg_fire      = cfg.cfg_valid && ready_q;

  // Out-of-range channel numbers match no channel, so the write is dropped.
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    localparam logic [CH_W-1:0] CH_ID = CH_W'(c);

    jk_channel #(
      .WIDTH   (WIDTH),
      .CNT_W   (CNT_W),
      .RST_VAL (RST_VAL)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .en         (en[c]),
      .j          (j[c*WIDTH +: WIDTH]),
      .k          (k[c*WIDTH +: WIDTH]),
      .mode_we    (cfg_fire && (cfg.cfg_ch == CH_ID)),
      .mode_wdata (cfg.cfg_mode),
      .cnt_clr    (cnt_clr[c]),
      .q          (q[c*WIDTH +: WIDTH]),
      .chg        (chg[c]),
      .cnt        (cnt[c*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_jk_reg_bank.sv
// Scoreboard bench for jk_reg_bank: a 4x8 bank plus a 1x8 bank with a 2-bit counter.
module tb_jk_reg_bank;
  import jk_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] j, k, q, cnt;
  logic [3:0]  en, chg, cnt_clr;
  logic [7:0]  j2, k2, q2;
  logic [0:0]  en2, chg2, cnt_clr2;
  logic [1:0]  cnt2;

  jk_reg_bank_if #(.CH_W(2)) cfg_if ();
  jk_reg_bank_if #(.CH_W(1)) cfg2_if ();

  jk_reg_bank #(.NCH(4), .WIDTH(8), .CNT_W(8), .RST_VAL(8'h00)) u_dut (
    .clk(clk), .rst(rst), .j(j), .k(k), .en(en), .cfg(cfg_if),
    .q(q), .chg(chg), .cnt_clr(cnt_clr), .cnt(cnt)
  );

  jk_reg_bank #(.NCH(1), .WIDTH(8), .CNT_W(2), .RST_VAL(8'h00)) u_dut2 (
    .clk(clk), .rst(rst), .j(j2), .k(k2), .en(en2), .cfg(cfg2_if),
    .q(q2), .chg(chg2), .cnt_clr(cnt_clr2), .cnt(cnt2)
  );

  localparam int K_Q = 0, K_CHG = 1, K_CNT = 2, K_RDY = 3, K_Q2 = 4, K_CNT2 = 5, K_CHG2 = 6;

  typedef struct {
    int          cyc;
    string       name;
    int          kind;
    int          idx;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Expectation applies to the outputs after the next rising edge.
  task automatic expect_v(input string name, input int kind, input int idx, input logic [31:0] v);
    exp_t e;
    e.cyc = cyc + 1; e.name = name; e.kind = kind; e.idx = idx; e.exp = v;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setjk(input int c, input logic [7:0] jv, input logic [7:0] kv);
    j[c*8 +: 8] = jv;
    k[c*8 +: 8] = kv;
  endtask

  function automatic logic [31:0] actual(input int kind, input int idx);
    case (kind)
      K_Q:     return {24'h0, q[idx*8 +: 8]};
      K_CHG:   return {31'h0, chg[idx]};
      K_CNT:   return {24'h0, cnt[idx*8 +: 8]};
      K_RDY:   return {31'h0, cfg_if.cfg_ready};
      K_Q2:    return {24'h0, q2};
      K_CNT2:  return {30'h0, cnt2};
      default: return {31'h0, chg2[0]};
    endcase
  endfunction

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      logic [31:0] a;
      e = sb.pop_front();
      a = actual(e.kind, e.idx);
      checks++;
      if (a !== e.exp) begin
        errors++;
        $display("FAIL %s[%0d]: got %0h expected %0h (cycle %0d)", e.name, e.idx, a, e.exp, cyc);
      end
    end
  end

  initial begin
    rst = 1'b1; j = '0; k = '0; en = '0; cnt_clr = '0;
    j2 = '0; k2 = '0; en2 = '0; cnt_clr2 = '0;
    cfg_if.cfg_valid = 1'b0; cfg_if.cfg_ch = '0; cfg_if.cfg_mode = MODE_JK;
    cfg2_if.cfg_valid = 1'b0; cfg2_if.cfg_ch = '0; cfg2_if.cfg_mode = MODE_JK;
    tick();

    for (int c = 0; c < 4; c++) begin
      expect_v("rst_q", K_Q, c, 32'h00);
      expect_v("rst_cnt", K_CNT, c, 32'h00);
    end
    expect_v("rst_rdy", K_RDY, 0, 0);
    tick();

    // Release; a write offered during INIT must not be taken.
    rst = 1'b0;
    cfg_if.cfg_valid = 1'b1; cfg_if.cfg_ch = 2'd1; cfg_if.cfg_mode = MODE_D;
    expect_v("init_rdy", K_RDY, 0, 0);
    tick();
    expect_v("run_rdy", K_RDY, 0, 1);
    tick();
    cfg_if.cfg_valid = 1'b0;

    // Ch1 is still JK: j=k=0 must hold, which D would not.
    en = 4'b0010; setjk(1, 8'hFF, 8'h00);
    expect_v("ch1_set", K_Q, 1, 32'hFF);
    tick();
    setjk(1, 8'h00, 8'h00);
    expect_v("ch1_init_nowrite", K_Q, 1, 32'hFF);
    tick();
    setjk(1, 8'h00, 8'hFF);
    expect_v("ch1_clr", K_Q, 1, 32'h00);
    tick();

    // Ch0 JK set/clear then toggle.
    en = 4'b0001; setjk(0, 8'hF0, 8'h0F);
    expect_v("ch0_jk1", K_Q, 0, 32'hF0);
    expect_v("ch0_chg1", K_CHG, 0, 1);
    expect_v("ch0_cnt1", K_CNT, 0, 1);
    tick();
    setjk(0, 8'hFF, 8'hFF);
    expect_v("ch0_jk_tog", K_Q, 0, 32'h0F);
    expect_v("ch0_chg2", K_CHG, 0, 1);
    expect_v("ch0_cnt2", K_CNT, 0, 2);
    tick();
    en = 4'b0000;
    expect_v("ch0_en_hold", K_Q, 0, 32'h0F);
    expect_v("ch0_chg_hold", K_CHG, 0, 0);
    expect_v("ch0_cnt_hold", K_CNT, 0, 2);
    tick();

    // Mode write to ch1 shares an edge with a data update that uses old JK mode.
    en = 4'b0010; setjk(1, 8'hAA, 8'h00);
    cfg_if.cfg_valid = 1'b1; cfg_if.cfg_ch = 2'd1; cfg_if.cfg_mode = MODE_D;
    expect_v("ch1_oldmode", K_Q, 1, 32'hAA);
    tick();
    cfg_if.cfg_valid = 1'b0;
    setjk(1, 8'h55, 8'hFF);
    expect_v("ch1_d", K_Q, 1, 32'h55);
    tick();
    setjk(1, 8'h0F, 8'h0F);
    expect_v("ch1_d_kign", K_Q, 1, 32'h0F);
    tick();

    en = 4'b0000;
    cfg_if.cfg_valid = 1'b1; cfg_if.cfg_ch = 2'd2; cfg_if.cfg_mode = MODE_SR;
    tick();
    cfg_if.cfg_ch = 2'd3; cfg_if.cfg_mode = MODE_T;
    tick();
    cfg_if.cfg_valid = 1'b0;

    // Ch2 SR: reset dominant, then set, then clear.
    en = 4'b0100; setjk(2, 8'hFF, 8'hFF);
    expect_v("ch2_sr11", K_Q, 2, 32'h00);
    expect_v("ch2_chg0", K_CHG, 2, 0);
    expect_v("ch2_cnt0", K_CNT, 2, 0);
    tick();
    setjk(2, 8'h0F, 8'h00);
    expect_v("ch2_set", K_Q, 2, 32'h0F);
    tick();
    setjk(2, 8'h00, 8'h03);
    expect_v("ch2_clr", K_Q, 2, 32'h0C);
    tick();

    // Ch3 T with en 1,0,1.
    en = 4'b1000; setjk(3, 8'h01, 8'h00);
    expect_v("ch3_t1", K_Q, 3, 32'h01);
    tick();
    en = 4'b0000;
    expect_v("ch3_hold", K_Q, 3, 32'h01);
    expect_v("ch3_chg_hold", K_CHG, 3, 0);
    tick();
    en = 4'b1000;
    expect_v("ch3_t2", K_Q, 3, 32'h00);
    expect_v("ch3_cnt", K_CNT, 3, 2);
    tick();
    en = 4'b0000;

    // 2-bit counter saturation on the second bank.
    en2 = 1'b1; j2 = 8'hFF; k2 = 8'hFF;
    for (int i = 1; i <= 5; i++) begin
      expect_v("sat_q", K_Q2, i, (i % 2 == 1) ? 32'hFF : 32'h00);
      expect_v("sat_cnt", K_CNT2, i, (i < 3) ? i : 3);
      tick();
    end
    cnt_clr2 = 1'b1;
    expect_v("clr_q", K_Q2, 0, 32'h00);
    expect_v("clr_chg", K_CHG2, 0, 1);
    expect_v("clr_cnt", K_CNT2, 0, 0);
    tick();
    cnt_clr2 = 1'b0;
    expect_v("after_clr_cnt", K_CNT2, 0, 1);
    tick();
    en2 = 1'b0;

    // Reset mid-stream with a pending write and all channels enabled.
    rst = 1'b1; en = 4'hF; j = '1; k = '1;
    cfg_if.cfg_valid = 1'b1; cfg_if.cfg_ch = 2'd0; cfg_if.cfg_mode = MODE_D;
    for (int c = 0; c < 4; c++) begin
      expect_v("mrst_q", K_Q, c, 32'h00);
      expect_v("mrst_cnt", K_CNT, c, 32'h00);
      expect_v("mrst_chg", K_CHG, c, 0);
    end
    expect_v("mrst_rdy", K_RDY, 0, 0);
    tick();

    // Modes back to JK everywhere: toggle, hold, clear distinguishes D/T/SR.
    rst = 1'b0; cfg_if.cfg_valid = 1'b0;
    j = '1; k = '1;
    for (int c = 0; c < 4; c++) expect_v("post_tog", K_Q, c, 32'hFF);
    tick();
    j = '0; k = '0;
    for (int c = 0; c < 4; c++) expect_v("post_hold", K_Q, c, 32'hFF);
    expect_v("post_rdy", K_RDY, 0, 1);
    tick();
    j = '0; k = '1;
    for (int c = 0; c < 4; c++) begin
      expect_v("post_clr", K_Q, c, 32'h00);
      expect_v("post_cnt", K_CNT, c, 2);
    end
    tick();
    en = '0;

    for (int i = 0; i < 4 && sb.size() > 0; i++) tick();
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
